// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32 control FSM
//
// Purpose: state enumeration, opcode constants, ALU mux/op encodings, fault
// cause encoding and the packed bundle of datapath control outputs.
// Ports: none (package).
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    ALU_WB,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    FAULT
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RS2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } fault_cause_e;

  // Every datapath mux select / enable driven by the controller.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       instr_done;
  } ctrl_t;

  // States that issue a memory request and wait on mem_ready.
  function automatic logic is_mem_wait_state(state_e s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
//
// Purpose: groups the opcode/memory handshake inputs and all control outputs.
// master modport: the controller (drives controls, reads opcode/mem_ready).
// slave modport : the datapath/memory side (drives opcode/mem_ready).
// Signals: opcode[6:0], mem_ready, pc_write, pc_write_cond, i_or_d, mem_read,
//          mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
//          alu_op[1:0], pc_source, instr_done, fault, fault_cause[1:0].
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [6:0]   opcode;
  logic         mem_ready;
  logic         pc_write;
  logic         pc_write_cond;
  logic         i_or_d;
  logic         mem_read;
  logic         mem_write;
  logic         ir_write;
  logic         mem_to_reg;
  logic         reg_write;
  logic         alu_src_a;
  logic [1:0]   alu_src_b;
  logic [1:0]   alu_op;
  logic         pc_source;
  logic         instr_done;
  logic         fault;
  fault_cause_e fault_cause;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, fault, fault_cause
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, fault, fault_cause
  );

endinterface

// File: rtl/multicycle_ctrl_timer.sv
// rtl/multicycle_ctrl_timer.sv - memory wait timeout counter
//
// Purpose: counts cycles spent waiting on mem_ready; flags when TMO_MAX reached.
// Ports: clk, rst_n (async active-low), clear_i (zero the count),
//        en_i (count one wait cycle), expired_o (count == TMO_MAX).
module mem_wait_timer #(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  assign expired_o = (count_q == TMO_W'(TMO_MAX));

  // Saturate at TMO_MAX; the FSM leaves the wait state on that cycle anyway.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multi-cycle RV32 subset datapath
//
// Purpose: sequences FETCH/DECODE/EXECUTE/MEM/WB for R-type, lw, sw and beq,
// stalls on mem_ready, and parks in a sticky FAULT state on an illegal opcode
// or a memory access that waits longer than TMO_MAX cycles.
// Ports: clk, rst_n (async active-low), bus (multicycle_ctrl_if.master:
//        opcode/mem_ready in, every datapath control plus fault/fault_cause out).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  state_e       state_q;
  state_e       state_d;
  logic         is_lw_q;
  logic         is_lw_d;
  fault_cause_e cause_q;
  fault_cause_e cause_d;
  ctrl_t        ctrl;

  logic         mem_ready;
  logic [6:0]   opcode;
  logic         waiting;
  logic         tmo_expired;

  assign mem_ready = bus.mem_ready;
  assign opcode    = bus.opcode;
  assign waiting   = is_mem_wait_state(state_q);

  // Holding the count at zero outside wait states (and on the completing
  // cycle) gives a clean zero on every entry to FETCH/MEM_RD/MEM_WR.
  mem_wait_timer #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!waiting || mem_ready),
    .en_i      (waiting && !mem_ready),
    .expired_o (tmo_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_lw_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // ready wins over an expiring timer
        if (mem_ready) begin
          state_d = DECODE;
        end else if (tmo_expired) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R:   state_d = EXEC;
          OP_LW: begin
            state_d = MEM_ADDR;
            is_lw_d = 1'b1;
          end
          OP_SW: begin
            state_d = MEM_ADDR;
            is_lw_d = 1'b0;
          end
          OP_BEQ: state_d = BRANCH;
          default: begin
            state_d = FAULT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      EXEC:     state_d = ALU_WB;
      ALU_WB:   state_d = FETCH;
      // lw/sw choice comes from the DECODE-time latch, not the live opcode
      MEM_ADDR: state_d = is_lw_q ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (mem_ready) begin
          state_d = MEM_WB;
        end else if (tmo_expired) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      MEM_WB:   state_d = FETCH;
      MEM_WR: begin
        if (mem_ready) begin
          state_d = FETCH;
        end else if (tmo_expired) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      BRANCH:   state_d = FETCH;
      FAULT:    state_d = FAULT;
      default:  state_d = FAULT;
    endcase
  end

  // Output logic: Moore per state, plus the mem_ready-qualified strobes.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end
      end
      DECODE: begin
        // speculative branch target into ALUOut
        ctrl.alu_src_b = SRCB_IMM_SH1;
        ctrl.alu_op    = ALU_ADD;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RS2;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.fault         = (state_q == FAULT);
  assign bus.fault_cause   = cause_q;

endmodule
